// File: rtl/mips_fetch_unit.sv
// MIPS32 instruction-fetch stage: keeps the fetch PC, issues word reads to a
// synchronous instruction memory and queues the responses in a prefetch FIFO.
module mips_fetch_unit #(
    parameter int              PC_W       = 32,
    parameter int              DATA_W     = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [PC_W-1:0]               imem_addr,
    input  logic [DATA_W-1:0]             imem_rdata,
    input  logic                          redirect_valid,
    input  logic [PC_W-1:0]               redirect_pc,
    input  logic                          halt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_instr,
    output logic [PC_W-1:0]               out_pc,
    output logic [PC_W-1:0]               out_npc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              stale_q, stale_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] instr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] instr_d [FIFO_DEPTH];
    logic [PC_W-1:0]   pc_q    [FIFO_DEPTH];
    logic [PC_W-1:0]   pc_d    [FIFO_DEPTH];
    logic [PC_W-1:0]   npc_q   [FIFO_DEPTH];
    logic [PC_W-1:0]   npc_d   [FIFO_DEPTH];

    logic [CNT_W:0]    credit;
    logic              issue_ok;
    logic              push;
    logic              pop;

    // Credits count both queued entries and the one response still in flight,
    // so a push can never find the FIFO full.
    assign credit     = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    assign issue_ok   = credit < (CNT_W+1)'(FIFO_DEPTH);
    assign imem_req   = !rst && !halt && !redirect_valid && issue_ok;
    assign imem_addr  = fetch_pc_q;

    assign out_valid  = (count_q != '0);
    assign out_instr  = instr_q[rd_ptr_q];
    assign out_pc     = pc_q[rd_ptr_q];
    assign out_npc    = npc_q[rd_ptr_q];
    assign fifo_count = count_q;

    assign pop  = out_valid && out_ready;
    assign push = inflight_q && !stale_q && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        stale_d    = stale_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        npc_d      = npc_q;

        if (imem_req) begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
            req_pc_d   = fetch_pc_q;
        end

        if (inflight_q) begin
            stale_d = 1'b0;
        end

        if (push) begin
            instr_d[wr_ptr_q] = imem_rdata;
            pc_d[wr_ptr_q]    = req_pc_q;
            npc_d[wr_ptr_q]   = req_pc_q + PC_W'(1);
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A handshake in this cycle still completes; the flush applies after it.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            stale_d    = imem_req;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            stale_q    <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                npc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                pc_q[i]    <= pc_d[i];
                npc_q[i]   <= npc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: per-cycle vector table for the main
// instance plus hand sequences for async reset and 4-bit PC wrap-around.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_npc;
    logic [2:0]  fifo_count;

    logic        rst_w;
    logic        imem_req_w;
    logic [3:0]  imem_addr_w;
    logic [31:0] imem_rdata_w = '0;
    logic        redirect_valid_w = 1'b0;
    logic [3:0]  redirect_pc_w = '0;
    logic        halt_w = 1'b0;
    logic        out_valid_w;
    logic        out_ready_w = 1'b1;
    logic [31:0] out_instr_w;
    logic [3:0]  out_pc_w;
    logic [3:0]  out_npc_w;
    logic [2:0]  fifo_count_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_fetch_unit #(.PC_W(32), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_npc(out_npc), .fifo_count(fifo_count)
    );

    mips_fetch_unit #(.PC_W(4), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(4'd14)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .halt(halt_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .out_instr(out_instr_w),
        .out_pc(out_pc_w), .out_npc(out_npc_w), .fifo_count(fifo_count_w)
    );

    // Instruction memories: one-cycle read latency, word at address a holds a*4.
    always @(posedge clk) imem_rdata   <= imem_addr * 32'd4;
    always @(posedge clk) imem_rdata_w <= {28'd0, imem_addr_w} * 32'd4;

    typedef struct {
        logic        halt;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic        req;
        logic [31:0] addr;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic h, logic r, logic [31:0] rp, logic rd,
                                logic v, logic [31:0] p, logic q, logic [31:0] a, logic [2:0] c);
        vec_t t;
        t.halt = h; t.redir = r; t.rpc = rp; t.ready = rd;
        t.valid = v; t.pc = p; t.req = q; t.addr = a; t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // stream from reset
        vecs.push_back(mk(0,0,0,1, 0,0,    1,0,    0));
        vecs.push_back(mk(0,0,0,1, 0,0,    1,1,    0));
        vecs.push_back(mk(0,0,0,1, 1,0,    1,2,    1));
        vecs.push_back(mk(0,0,0,1, 1,1,    1,3,    1));
        vecs.push_back(mk(0,0,0,1, 1,2,    1,4,    1));
        vecs.push_back(mk(0,0,0,1, 1,3,    1,5,    1));
        // backpressure: 10 cycles of out_ready=0
        vecs.push_back(mk(0,0,0,0, 1,4,    1,6,    1));
        vecs.push_back(mk(0,0,0,0, 1,4,    1,7,    2));
        vecs.push_back(mk(0,0,0,0, 1,4,    0,0,    3));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,0,0, 1,4, 0,0, 4));
        vecs.push_back(mk(0,0,0,1, 1,4,    0,0,    4));
        vecs.push_back(mk(0,0,0,1, 1,5,    1,8,    3));
        vecs.push_back(mk(0,0,0,1, 1,6,    1,9,    2));
        vecs.push_back(mk(0,0,0,1, 1,7,    1,10,   2));
        vecs.push_back(mk(0,0,0,1, 1,8,    1,11,   2));
        vecs.push_back(mk(0,0,0,1, 1,9,    1,12,   2));
        // build 3 entries, then redirect to 0x40
        vecs.push_back(mk(0,0,0,0, 1,10,   1,13,   2));
        vecs.push_back(mk(0,1,32'h40,0, 1,10, 0,0, 3));
        vecs.push_back(mk(0,0,0,1, 0,0,    1,32'h40, 0));
        vecs.push_back(mk(0,0,0,1, 0,0,    1,32'h41, 0));
        vecs.push_back(mk(0,0,0,1, 1,32'h40, 1,32'h42, 1));
        vecs.push_back(mk(0,0,0,1, 1,32'h41, 1,32'h43, 1));
        // halt for 5 cycles
        vecs.push_back(mk(1,0,0,1, 1,32'h42, 0,0, 1));
        vecs.push_back(mk(1,0,0,1, 1,32'h43, 0,0, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,1, 0,0, 0,0, 0));
        vecs.push_back(mk(0,0,0,1, 0,0,    1,32'h44, 0));
        vecs.push_back(mk(0,0,0,1, 0,0,    1,32'h45, 0));
        vecs.push_back(mk(0,0,0,1, 1,32'h44, 1,32'h46, 1));
        // redirect while halted
        vecs.push_back(mk(1,1,32'h80,1, 1,32'h45, 0,0, 1));
        vecs.push_back(mk(1,0,0,1, 0,0,    0,0,    0));
        vecs.push_back(mk(0,0,0,1, 0,0,    1,32'h80, 0));
        vecs.push_back(mk(0,0,0,1, 0,0,    1,32'h81, 0));
        vecs.push_back(mk(0,0,0,1, 1,32'h80, 1,32'h82, 1));
        // grow to two entries before the async reset
        vecs.push_back(mk(0,0,0,0, 1,32'h81, 1,32'h83, 1));
        vecs.push_back(mk(0,0,0,0, 1,32'h81, 1,32'h84, 2));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_npc", out_npc, 0);
        chk("rst_w_out_valid", out_valid_w, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst            = 1'b0;
            halt           = vecs[i].halt;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].ready;
            #1;
            chk($sformatf("c%0d_out_valid", i), out_valid, vecs[i].valid);
            chk($sformatf("c%0d_fifo_count", i), fifo_count, vecs[i].cnt);
            chk($sformatf("c%0d_imem_req", i), imem_req, vecs[i].req);
            if (vecs[i].req)
                chk($sformatf("c%0d_imem_addr", i), imem_addr, vecs[i].addr);
            if (vecs[i].valid) begin
                chk($sformatf("c%0d_out_pc", i), out_pc, vecs[i].pc);
                chk($sformatf("c%0d_out_instr", i), out_instr, vecs[i].pc * 32'd4);
                chk($sformatf("c%0d_out_npc", i), out_npc, vecs[i].pc + 32'd1);
            end
        end

        // asynchronous reset between edges with two entries queued
        #1 rst = 1'b1;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_imem_req", imem_req, 0);
        chk("async_fifo_count", fifo_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 0);
        chk("restart_valid0", out_valid, 0);
        @(posedge clk);
        #2;
        chk("restart_addr1", imem_addr, 1);
        chk("restart_valid1", out_valid, 0);
        @(posedge clk);
        #2;
        chk("restart_valid2", out_valid, 1);
        chk("restart_pc", out_pc, 0);
        chk("restart_instr", out_instr, 0);

        // 4-bit PC wrap-around from RESET_PC=14
        @(posedge clk);
        #1 rst_w = 1'b0;
        #1;
        chk("wrap_addr0", imem_addr_w, 14);
        @(posedge clk);
        #2;
        chk("wrap_addr1", imem_addr_w, 15);
        chk("wrap_valid1", out_valid_w, 0);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] epc;
            epc = 4'(14 + k);
            @(posedge clk);
            #2;
            chk($sformatf("wrap%0d_valid", k), out_valid_w, 1);
            chk($sformatf("wrap%0d_pc", k), out_pc_w, epc);
            chk($sformatf("wrap%0d_npc", k), out_npc_w, 4'(epc + 4'd1));
            chk($sformatf("wrap%0d_instr", k), out_instr_w, {28'd0, epc} * 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
